// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the segmented pipelined adder.
// - MODE_ADD / MODE_SUB: encodings of the per-transaction 'sub' input.
// - calc_seg_w(): segment width, or 0 when the parameter set is illegal.
//   Returns 0 when NUM_SEG is out of range or does not divide INP_DW.
// The transaction struct depends on the top's parameters, so it is declared
// there from localparams.
package pipelined_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_seg_w(input int inp_dw, input int num_seg);
    if (num_seg < 1 || num_seg > inp_dw || (inp_dw % num_seg) != 0) begin
      return 0;
    end
    return inp_dw / num_seg;
  endfunction

endpackage

// File: rtl/pipelined_adder_seg_stage.sv
// adder_seg_stage: one carry segment of the pipelined adder plus its register.
// Adds segment IDX of in_a/in_b with in_carry, writes that segment into the
// partial sum, and registers sum, carry-out, remaining operands, tag and
// valid. All registers hold when en=0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en                    advance enable (load when 1, hold when 0)
//   in_*                  transaction from the previous stage (or the input)
//   out_*                 registered transaction for the next stage
module adder_seg_stage
  import pipelined_adder_pkg::*;
#(
  parameter int INP_DW = 8,
  parameter int SEG_W  = 4,
  parameter int TAG_W  = 4,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [INP_DW-1:0] in_sum,
  input  logic [INP_DW-1:0] in_a,
  input  logic [INP_DW-1:0] in_b,
  input  logic              in_carry,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [INP_DW-1:0] out_sum,
  output logic [INP_DW-1:0] out_a,
  output logic [INP_DW-1:0] out_b,
  output logic              out_carry,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int LO = IDX * SEG_W;

  logic [SEG_W:0]      seg_res;
  logic                valid_d, valid_q;
  logic [INP_DW-1:0]   sum_d, sum_q;
  logic [INP_DW-1:0]   a_d, a_q;
  logic [INP_DW-1:0]   b_d, b_q;
  logic                carry_d, carry_q;
  logic [TAG_W-1:0]    tag_d, tag_q;

  always_comb begin
    // Segment add: MSB of seg_res is the carry handed to the next stage.
    seg_res = {1'b0, in_a[LO +: SEG_W]} + {1'b0, in_b[LO +: SEG_W]}
            + (SEG_W+1)'(in_carry);

    valid_d = valid_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    tag_d   = tag_q;
    if (en) begin
      valid_d            = in_valid;
      // Lower segments pass through unchanged; this stage fills segment IDX.
      sum_d              = in_sum;
      sum_d[LO +: SEG_W] = seg_res[SEG_W-1:0];
      a_d                = in_a;
      b_d                = in_b;
      carry_d            = seg_res[SEG_W];
      tag_d              = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_carry = carry_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/pipelined_adder_seg.sv
// pipelined_adder_seg: INP_DW-bit add/subtract whose carry chain is cut into
// NUM_SEG registered segments; the carry ripples one segment per cycle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake; inp1, inp2, sub, in_tag payload
//   out_valid/out_ready        output handshake; outp ({carry, sum}), out_tag
// Handshake: a beat transfers on a rising edge where valid && ready. The
// whole pipeline advances when the output register is empty or being
// consumed (adv = !out_valid || out_ready); in_ready equals adv and does not
// look at in_valid. Empty slots (bubbles) travel through and are not squeezed.
// Subtraction is A + ~B + 1, so outp[INP_DW]=1 means no borrow (A >= B).
module pipelined_adder_seg
  import pipelined_adder_pkg::*;
#(
  parameter int INP_DW  = 8,
  parameter int NUM_SEG = 2,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INP_DW-1:0] inp1,
  input  logic [INP_DW-1:0] inp2,
  input  logic              sub,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INP_DW:0]   outp,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int SEG_W = calc_seg_w(INP_DW, NUM_SEG);

  if (SEG_W == 0) begin : g_bad_seg
    $error("pipelined_adder_seg: NUM_SEG must be 1..INP_DW and divide INP_DW");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("pipelined_adder_seg: TAG_W must be at least 1");
  end

  typedef struct packed {
    logic [INP_DW-1:0] data;
    logic              carry;
    logic [TAG_W-1:0]  tag;
    logic              valid;
  } xact_t;

  // Element 0 is the incoming transaction; element k+1 is stage k's register.
  xact_t             stg_x [NUM_SEG+1];
  logic [INP_DW-1:0] op_a  [NUM_SEG+1];
  logic [INP_DW-1:0] op_b  [NUM_SEG+1];
  logic              adv;

  assign adv      = !stg_x[NUM_SEG].valid || out_ready;
  assign in_ready = adv;

  // Inverting B and seeding the carry with 'sub' turns the add into A - B.
  assign stg_x[0].data  = '0;
  assign stg_x[0].carry = (sub == MODE_SUB);
  assign stg_x[0].tag   = in_tag;
  assign stg_x[0].valid = in_valid;
  assign op_a[0]        = inp1;
  assign op_b[0]        = (sub == MODE_SUB) ? ~inp2 : inp2;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
    adder_seg_stage #(
      .INP_DW (INP_DW),
      .SEG_W  (SEG_W),
      .TAG_W  (TAG_W),
      .IDX    (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (adv),
      .in_valid  (stg_x[k].valid),
      .in_sum    (stg_x[k].data),
      .in_a      (op_a[k]),
      .in_b      (op_b[k]),
      .in_carry  (stg_x[k].carry),
      .in_tag    (stg_x[k].tag),
      .out_valid (stg_x[k+1].valid),
      .out_sum   (stg_x[k+1].data),
      .out_a     (op_a[k+1]),
      .out_b     (op_b[k+1]),
      .out_carry (stg_x[k+1].carry),
      .out_tag   (stg_x[k+1].tag)
    );
  end

  // Every segment has been consumed by the last stage.
  logic unused_ops;
  assign unused_ops = ^{op_a[NUM_SEG], op_b[NUM_SEG]};

  assign out_valid = stg_x[NUM_SEG].valid;
  assign outp      = {stg_x[NUM_SEG].carry, stg_x[NUM_SEG].data};
  assign out_tag   = stg_x[NUM_SEG].tag;

endmodule
